// File: rtl/vh_result_checker.sv
// Compares DUT results against golden results over a fixed-length run and reports errors.
// Latency: results visible one cycle after each transfer; done pulses the cycle after the last transfer.
// Backpressure: in_ready is high only while the run is active; optional MISR signature with VH_MISR_EN.
module vh_result_checker #(
    parameter int VEC_COUNT = 256,
    parameter int YW        = 90
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [YW-1:0] dut_y,
    input  logic [YW-1:0] exp_y,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [15:0]   err_count,
    output logic [15:0]   first_err_idx,
    output logic [YW-1:0] first_err_diff
`ifdef VH_MISR_EN
    ,
    output logic [31:0]   signature
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] LAST_IDX = 16'(VEC_COUNT - 1);

    state_t          state_q, state_d;
    logic [15:0]     idx_q, idx_d;
    logic [15:0]     err_count_q, err_count_d;
    logic [15:0]     first_err_idx_q, first_err_idx_d;
    logic [YW-1:0]   first_err_diff_q, first_err_diff_d;
    logic            pass_q, pass_d;
    logic            xfer;
    logic            mismatch;
    logic [YW-1:0]   diff;

    assign xfer     = in_valid && (state_q == RUN);
    assign diff     = dut_y ^ exp_y;
    assign mismatch = |diff;

    assign in_ready       = (state_q == RUN);
    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);
    assign pass           = pass_q;
    assign err_count      = err_count_q;
    assign first_err_idx  = first_err_idx_q;
    assign first_err_diff = first_err_diff_q;

    // Next-state, run bookkeeping and error capture; a zero err_count marks "no mismatch yet".
    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        err_count_d      = err_count_q;
        first_err_idx_d  = first_err_idx_q;
        first_err_diff_d = first_err_diff_q;
        pass_d           = pass_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d          = RUN;
                    idx_d            = '0;
                    err_count_d      = '0;
                    first_err_idx_d  = '0;
                    first_err_diff_d = '0;
                    pass_d           = 1'b0;
                end
            end
            RUN: begin
                if (xfer) begin
                    idx_d = idx_q + 16'd1;
                    if (mismatch) begin
                        if (err_count_q == 16'd0) begin
                            first_err_idx_d  = idx_q;
                            first_err_diff_d = diff;
                        end
                        if (err_count_q != 16'hFFFF) begin
                            err_count_d = err_count_q + 16'd1;
                        end
                    end
                    // Pass is resolved with the final transfer folded in so it is valid during DONE.
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                        pass_d  = (err_count_d == 16'd0);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            idx_q            <= '0;
            err_count_q      <= '0;
            first_err_idx_q  <= '0;
            first_err_diff_q <= '0;
            pass_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            err_count_q      <= err_count_d;
            first_err_idx_q  <= first_err_idx_d;
            first_err_diff_q <= first_err_diff_d;
            pass_q           <= pass_d;
        end
    end

`ifdef VH_MISR_EN
    localparam int NW = (YW + 31) / 32;

    logic [NW*32-1:0] pad;
    logic [31:0]      fold;
    logic [31:0]      signature_q, signature_d;

    assign signature = signature_q;

    // Fold the zero-padded result into one word, then advance the CRC-32 polynomial MISR.
    always_comb begin
        pad            = '0;
        pad[YW-1:0]    = dut_y;
        fold           = '0;
        for (int w = 0; w < NW; w++) begin
            fold = fold ^ pad[w*32 +: 32];
        end
        signature_d = signature_q;
        if (state_q == IDLE && start) begin
            signature_d = 32'hFFFFFFFF;
        end else if (xfer) begin
            signature_d = (signature_q << 1)
                        ^ (signature_q[31] ? 32'h04C11DB7 : 32'h0)
                        ^ fold;
        end
    end

    // Signature register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            signature_q <= 32'hFFFFFFFF;
        end else begin
            signature_q <= signature_d;
        end
    end
`endif

endmodule

// File: doc/vh_result_checker.md
VH_RESULT_CHECKER -- requirements
Module: vh_result_checker

Interface
REQ-001 The block SHALL have parameter VEC_COUNT, default 256, giving the number of result vectors checked per run (range 1..65535).
REQ-002 The block SHALL have parameter YW, default 90, giving the width of the packed expression result y.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset; the clock and reset ports are fixed as listed first below.
REQ-004 clk  input  1  single rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  one-cycle pulse that begins a run.
REQ-007 in_valid  input  1  dut_y/exp_y pair is valid this cycle.
REQ-008 in_ready  output  1  checker accepts a pair this cycle.
REQ-009 dut_y  input  YW  packed result from the expression-under-test stage.
REQ-010 exp_y  input  YW  golden result for the same operand vector.
REQ-011 busy  output  1  run in progress.
REQ-012 done  output  1  one-cycle pulse at end of run.
REQ-013 pass  output  1  last completed run had zero mismatches.
REQ-014 err_count  output  16  mismatches in current or last run.
REQ-015 first_err_idx  output  16  vector index of the first mismatch.
REQ-016 first_err_diff  output  YW  dut_y XOR exp_y at the first mismatch.
REQ-017 signature  output  32  MISR over accepted dut_y (present only with VH_MISR_EN).

Function
REQ-018 The FSM SHALL have states IDLE, RUN, DONE; IDLE->RUN on start, RUN->DONE in the cycle after the VEC_COUNT-th transfer, DONE->IDLE unconditionally after one cycle.
REQ-019 in_ready SHALL be 1 only in RUN; a transfer occurs iff in_valid && in_ready at a rising edge.
REQ-020 busy SHALL be 1 in RUN and DONE; done SHALL be 1 only in DONE.
REQ-021 On start in IDLE: the 16-bit vector index, err_count, first_err_idx and first_err_diff SHALL clear to 0 and pass to 0 in the same edge.
REQ-022 start in RUN or DONE SHALL be ignored; in_valid in IDLE or DONE SHALL be ignored (no transfer).
REQ-023 A transfer with dut_y != exp_y SHALL increment err_count one cycle later, saturating at 16'hFFFF.
REQ-024 On the first mismatch of a run only, first_err_idx SHALL capture the current vector index and first_err_diff SHALL capture dut_y ^ exp_y; later mismatches SHALL not overwrite them.
REQ-025 The vector index SHALL increment by 1 per transfer; the transfer at index VEC_COUNT-1 SHALL be the last.
REQ-026 In DONE, pass SHALL be set to (err_count == 0) including the final transfer's result; pass and all result outputs SHALL hold until the next start.
REQ-027 Comparison SHALL be exact bitwise over all YW bits; no X/Z handling is provided.

Reset
REQ-028 Asserting rst_n low SHALL immediately force IDLE, in_ready=0, busy=0, done=0, pass=0, err_count=0, first_err_idx=0, first_err_diff=0, signature=32'hFFFFFFFF, index=0.
REQ-029 Reset mid-run SHALL abort the run with no done pulse; release SHALL return to IDLE awaiting start.

Configuration
REQ-030 With macro VH_MISR_EN defined, signature SHALL exist, load 32'hFFFFFFFF on start, and on each transfer update to (sig<<1) ^ (sig[31] ? 32'h04C11DB7 : 0) ^ F, where F is the XOR of dut_y zero-padded to a multiple of 32 and split into 32-bit words.
REQ-031 Without VH_MISR_EN, the signature port and its register SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-032 VEC_COUNT=4, start, 4 transfers with dut_y==exp_y -> done one cycle after 4th transfer, pass=1, err_count=0.
REQ-033 VEC_COUNT=4, mismatch at index 2 with diff 90'h1 and at index 3 -> err_count=2, first_err_idx=2, first_err_diff=90'h1, pass=0.
REQ-034 in_valid toggled 1,0,1,0 in RUN -> only valid cycles count; done after exactly 4 accepted pairs.
REQ-035 rst_n pulsed low after 2 transfers -> outputs at reset values, no done; fresh start completes normally.
REQ-036 start asserted during RUN and in_valid in IDLE -> no restart, no counted transfer.
REQ-037 VH_MISR_EN, VEC_COUNT=1, dut_y=0 -> signature=32'hFFFFFFFE ^ 32'h04C11DB7 = 32'hFB3EE249.
